// File: rtl/num_string_scheduler_if.sv
// Requester-side handshake bundle for the num_string scheduler: two BCD word
// sources, each with a valid/data/ready triple.
interface num_string_scheduler_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/num_string_scheduler.sv
// Round-robin writer of the packed-BCD display word; accepted words are held and
// only committed at the start of vertical blanking so digits never tear mid-frame.
module num_string_scheduler #(
  parameter int unsigned V_ACTIVE    = 480,
  parameter logic [15:0] RESET_VALUE = 16'h0000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 p_tick_i,
  input  logic [9:0]           y_i,
  num_string_scheduler_if.slave req,
  output logic [15:0]          num_string_o,
  output logic                 pending_o,
  output logic [CNT_W-1:0]     frame_count_o,
  output logic                 err_bcd_o
);

  typedef enum logic [1:0] {StIdle, StHeld, StCommit} state_e;

  localparam logic [9:0] VLine = 10'(V_ACTIVE);
  localparam logic [9:0] VPrev = 10'(V_ACTIVE - 1);

  state_e             state_q;
  logic               last_grant_q;  // 1: port 1 won last, so port 0 wins a tie
  logic [9:0]         y_q;
  logic [15:0]        pend_word_q;
  logic [15:0]        num_string_q;
  logic               pending_q;
  logic [CNT_W-1:0]   frame_count_q;
  logic               err_bcd_q;

  logic               vblank_start;
  logic               idle;
  logic               grant0;
  logic               grant1;
  logic [15:0]        win_word;

  function automatic logic is_bcd(input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign vblank_start = p_tick_i && (y_i == VLine) && (y_q == VPrev);
  assign idle         = (state_q == StIdle);
  assign grant0       = idle & req.req0_valid & (~req.req1_valid | last_grant_q);
  assign grant1       = idle & req.req1_valid & (~req.req0_valid | ~last_grant_q);
  assign win_word     = grant1 ? req.req1_data : req.req0_data;

  // Readys are forced low while reset is held, independent of the flops.
  assign req.req0_ready = grant0 & rst_ni;
  assign req.req1_ready = grant1 & rst_ni;

  assign num_string_o  = num_string_q;
  assign pending_o     = pending_q;
  assign frame_count_o = frame_count_q;
  assign err_bcd_o     = err_bcd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      y_q           <= '0;
      pend_word_q   <= '0;
      num_string_q  <= RESET_VALUE;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      err_bcd_q     <= 1'b0;
    end else begin
      if (p_tick_i) y_q <= y_i;
      err_bcd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            last_grant_q <= grant1;
            if (is_bcd(win_word)) begin
              pend_word_q <= win_word;
              pending_q   <= 1'b1;
              state_q     <= StHeld;
            end else begin
              err_bcd_q <= 1'b1;
            end
          end
        end
        StHeld: begin
          if (vblank_start) state_q <= StCommit;
        end
        StCommit: begin
          num_string_q  <= pend_word_q;
          pending_q     <= 1'b0;
          frame_count_q <= frame_count_q + 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_num_string_scheduler.sv
// Scoreboard bench: a cycle reference model predicts grants and queues expected
// commits/errors; a separate monitor pops them as the DUT presents them.
module tb_num_string_scheduler;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        p_tick = 1'b0;
  logic [9:0]  y = 10'd0;
  logic [15:0] num_string;
  logic        pending;
  logic [7:0]  frame_count;
  logic        err_bcd;

  num_string_scheduler_if ifc ();

  num_string_scheduler #(
    .V_ACTIVE   (480),
    .RESET_VALUE(16'h0000),
    .CNT_W      (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .p_tick_i     (p_tick),
    .y_i          (y),
    .req          (ifc.slave),
    .num_string_o (num_string),
    .pending_o    (pending),
    .frame_count_o(frame_count),
    .err_bcd_o    (err_bcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line/pixel-tick generator ----------------
  int lines [14] = '{0, 1, 2, 3, 4, 5, 480, 6, 7, 8, 9, 479, 480, 481};
  int li = 0;
  bit gen_en = 1'b1;

  initial forever begin
    @(posedge clk);
    #1;
    if (gen_en) begin
      if (p_tick) begin
        li = (li + 1) % 14;
        y  = 10'(lines[li]);
      end
      p_tick = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          held = 1'b0;
  int          rel_cycle = -1;
  int          mdl_last = 1;
  int          last_tick_y = 0;
  logic [15:0] dq[$];
  int          ctq[$];
  int          errq[$];

  function automatic bit word_ok(input logic [15:0] w);
    int v;
    v = int'(w);
    for (int i = 0; i < 4; i++) begin
      if (((v >> (4 * i)) % 16) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit vb;
    int winner;
    if (rst_ni) begin
      cyc++;
      vb = p_tick && (y == 10'd480) && (last_tick_y == 479);
      if (p_tick) last_tick_y = int'(y);
      if (held && rel_cycle == cyc) held = 1'b0;
      winner = -1;
      if (!held) begin
        if (ifc.req0_valid && ifc.req1_valid) winner = 1 - mdl_last;
        else if (ifc.req0_valid)              winner = 0;
        else if (ifc.req1_valid)              winner = 1;
      end
      chk("req0_ready", ifc.req0_ready, winner == 0);
      chk("req1_ready", ifc.req1_ready, winner == 1);
      chk("pending", pending, held);
      if (held && rel_cycle < 0 && vb) begin
        rel_cycle = cyc + 2;
        ctq.push_back(cyc + 2);
      end
      if (winner >= 0) begin
        logic [15:0] w;
        w = (winner == 0) ? ifc.req0_data : ifc.req1_data;
        mdl_last = winner;
        if (word_ok(w)) begin
          held      = 1'b1;
          rel_cycle = -1;
          dq.push_back(w);
        end else begin
          errq.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] shown = 16'h0000;
  logic [7:0]  mon_fc = 8'd0;
  int          commits = 0;
  logic [15:0] log_q[$];

  always @(negedge clk) begin
    bit exp_err;
    #1;
    if (rst_ni) begin
      if (ctq.size() > 0 && ctq[0] == cyc) begin
        void'(ctq.pop_front());
        if (dq.size() == 0) chk("commit_data_missing", 1, 0);
        else shown = dq.pop_front();
        mon_fc++;
        commits++;
        log_q.push_back(shown);
      end
      chk("num_string", num_string, shown);
      chk("frame_count", frame_count, mon_fc);
      exp_err = (errq.size() > 0 && errq[0] == cyc);
      if (exp_err) void'(errq.pop_front());
      chk("err_bcd", err_bcd, exp_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic a0, a1;

  task automatic tick();
    @(negedge clk);
    a0 = ifc.req0_ready;
    a1 = ifc.req1_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  function automatic logic [15:0] rand_word();
    if ($urandom_range(0, 3) == 0) return 16'($urandom());
    return rand_bcd();
  endfunction

  task automatic send(input int port, input logic [15:0] data);
    bit acc;
    acc = 1'b0;
    if (port == 0) begin ifc.req0_valid = 1'b1; ifc.req0_data = data; end
    else           begin ifc.req1_valid = 1'b1; ifc.req1_data = data; end
    for (int b = 0; b < 2000 && !acc; b++) begin
      tick();
      acc = (port == 0) ? a0 : a1;
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic wait_commits(input int target);
    for (int b = 0; b < 20000 && commits < target; b++) tick();
    chk("commit_wait", commits >= target, 1);
  endtask

  task automatic wait_idle();
    for (int b = 0; b < 2000 && pending; b++) tick();
    chk("idle_wait", pending, 0);
  endtask

  task automatic clear_model();
    held = 1'b0; rel_cycle = -1; mdl_last = 1; last_tick_y = 0;
    dq.delete(); ctq.delete(); errq.delete();
    shown = 16'h0000; mon_fc = 8'd0;
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] rr_exp [4] = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};

  initial begin
    int base;
    logic [7:0] fc0;
    ifc.req0_valid = 1'b1; ifc.req0_data = 16'h1111;
    ifc.req1_valid = 1'b1; ifc.req1_data = 16'h2222;
    #12;
    chk("rst_ready0", ifc.req0_ready, 0);
    chk("rst_ready1", ifc.req1_ready, 0);
    chk("rst_num", num_string, 16'h0000);
    chk("rst_fc", frame_count, 0);
    chk("rst_pending", pending, 0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    #11 rst_ni = 1'b1;
    tick();

    // single write
    send(0, 16'h1234);
    wait_commits(1);
    chk("single_num", num_string, 16'h1234);
    chk("single_fc", frame_count, 1);
    chk("single_pending", pending, 0);

    // rejected word, then a legal one from the same port
    base = commits;
    send(1, 16'h12A4);
    repeat (40) tick();
    chk("bad_no_commit", commits, base);
    chk("bad_num", num_string, 16'h1234);
    send(1, 16'h0987);
    wait_commits(base + 1);
    chk("after_bad_num", num_string, 16'h0987);

    // round-robin with both ports always valid
    base = commits;
    ifc.req0_valid = 1'b1; ifc.req0_data = 16'h1111;
    ifc.req1_valid = 1'b1; ifc.req1_data = 16'h2222;
    wait_commits(base + 4);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (log_q.size() > base + i) chk("rr_order", log_q[base + i], rr_exp[i]);
      else chk("rr_order_missing", 0, 1);
    end

    // transfer on the same clock as vblank_start
    wait_idle();
    tick();
    base = commits;
    gen_en = 1'b0;
    y = 10'd479; p_tick = 1'b1;
    tick();
    y = 10'd480; ifc.req0_valid = 1'b1; ifc.req0_data = 16'h4321;
    tick();
    chk("edge_accept", a0, 1);
    ifc.req0_valid = 1'b0;
    p_tick = 1'b0; y = 10'd481;
    repeat (5) tick();
    chk("edge_still_pending", pending, 1);
    chk("edge_no_commit", commits, base);
    li = 13;
    gen_en = 1'b1;
    wait_commits(base + 1);
    chk("edge_num", num_string, 16'h4321);

    // 256 commits wrap the frame counter
    base = commits;
    fc0 = frame_count;
    ifc.req0_valid = 1'b1; ifc.req0_data = rand_bcd();
    for (int b = 0; b < 20000 && commits < base + 256; b++) begin
      tick();
      if (a0) ifc.req0_data = rand_bcd();
    end
    chk("wrap_count", commits, base + 256);
    chk("wrap_fc", frame_count, fc0);
    ifc.req0_valid = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!ifc.req0_valid || a0) begin
        ifc.req0_valid = ($urandom_range(0, 9) < 7);
        ifc.req0_data  = rand_word();
      end
      if (!ifc.req1_valid || a1) begin
        ifc.req1_valid = ($urandom_range(0, 9) < 7);
        ifc.req1_data  = rand_word();
      end
      tick();
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    wait_idle();

    // reset while a word is held
    send(0, 16'h5555);
    for (int b = 0; b < 50 && !pending; b++) tick();
    chk("pre_reset_pending", pending, 1);
    @(posedge clk);
    #3 rst_ni = 1'b0;
    clear_model();
    ifc.req0_valid = 1'b1; ifc.req0_data = 16'h1357;
    ifc.req1_valid = 1'b1; ifc.req1_data = 16'h2468;
    #4;
    chk("mid_rst_num", num_string, 16'h0000);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_err", err_bcd, 0);
    chk("mid_rst_ready0", ifc.req0_ready, 0);
    chk("mid_rst_ready1", ifc.req1_ready, 0);
    @(posedge clk);
    #3 rst_ni = 1'b1;
    tick();
    chk("tie_port0", a0, 1);
    chk("tie_port1", a1, 0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;

    // drain
    repeat (200) tick();
    chk("drain_data", dq.size(), 0);
    chk("drain_commit", ctq.size(), 0);
    chk("drain_err", errq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/num_string_scheduler.md
Name: num_string_scheduler

Overview:
- Owns the 16-bit packed-BCD `num_string` word that drives the ASCII text renderer. Two requesters write it: game/status logic on port 0 and a debug/counter source on port 1.
- Arbitrates between the requesters round-robin and rejects non-BCD words.
- Holds one accepted word in a pending buffer and commits it to the display only at the start of vertical blanking, so a digit never changes mid-frame.
- Sits between the requesters and the text renderer; uses `y` and `p_tick` from the VGA controller.

Parameters:
- V_ACTIVE, 480, first non-visible line; blanking starts when `y` reaches this value.
- RESET_VALUE, 16'h0000, `num_string` value after reset.
- CNT_W, 8, width of `frame_count`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel-clock enable from the VGA controller
- y  in  10  current line from the VGA controller
- req0_valid  in  1  requester 0 holds a word
- req0_data  in  16  requester 0 word, 4 BCD nibbles, MSD in [15:12]
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 holds a word
- req1_data  in  16  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle
- num_string  out  16  committed display word (registered)
- pending  out  1  pending buffer holds an uncommitted word
- frame_count  out  CNT_W  number of commits, modulo 2^CNT_W
- err_bcd  out  1  one-cycle pulse: an accepted word was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - outputs: `num_string`=RESET_VALUE, `pending`=0, `frame_count`=0, `err_bcd`=0, both readys=0.
  - internal: state=IDLE, `last_grant`=1 (port 0 wins the first tie), `y_d`=0.
  - Reset mid-HELD/COMMIT discards the pending word; `num_string` returns to RESET_VALUE.
- Frame-boundary detect:
  - `y_d` <= `y` on every clk with `p_tick`=1.
  - `vblank_start` = `p_tick` & (`y`==V_ACTIVE) & (`y_d`==V_ACTIVE-1). It is combinational and lasts one clk per frame.
- States: IDLE, HELD, COMMIT.
- Arbitration (IDLE only):
  - `req0_ready` = IDLE & `req0_valid` & (!`req1_valid` | `last_grant`==1).
  - `req1_ready` = IDLE & `req1_valid` & (!`req0_valid` | `last_grant`==0).
  - At most one ready is high per cycle. Both readys are 0 outside IDLE and while rst=0.
- Transfer (a ready is high at the clk edge):
  - `last_grant` <= the winning port.
  - Every nibble <=9: pending_reg <= data, state -> HELD, `pending`=1 from the next cycle.
  - Any nibble >9: word dropped, `err_bcd`=1 for exactly the next cycle, state stays IDLE. The requester sees a normal handshake.
- HELD:
  - No new accepts.
  - On `vblank_start` -> COMMIT.
- COMMIT (exactly 1 clk):
  - `num_string` <= pending_reg, `pending` <= 0, `frame_count` <= `frame_count`+1 (wraps 2^CNT_W-1 -> 0), state -> IDLE.
  - Net effect: `num_string` changes 2 clk edges after the `vblank_start` cycle, well inside blanking.
- Transfer coincident with `vblank_start`: the word enters HELD and waits for the next frame's `vblank_start`, not this one. `vblank_start` seen in IDLE or COMMIT has no effect.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1,… with at most one commit per frame.
- Identical back-to-back words still count as commits.
- `num_string` changes only in COMMIT. `frame_count` changes only in COMMIT.

Test Plan:
- Reset: assert rst=0 mid-HELD with pending=1 -> `num_string`=16'h0000, `pending`=0, `frame_count`=0, both readys 0 while rst=0; after release, first tie grants port 0.
- Single write: `req0_data`=16'h1234 in IDLE -> `req0_ready`=1 for one cycle, `pending`=1; `num_string` stays 16'h0000 until `y` steps 479->480 on `p_tick`; 2 clks later `num_string`=16'h1234, `frame_count`=1, `pending`=0.
- Round-robin: both valid every cycle (port0 16'h1111, port1 16'h2222) over 4 frames -> commits in order 1111, 2222, 1111, 2222; never two readys in one cycle.
- Bad BCD: `req1_data`=16'h12A4 -> `req1_ready`=1, `err_bcd`=1 for exactly one cycle, `pending` stays 0, `num_string` unchanged; the next legal word is accepted normally.
- Edge timing: transfer on the same clk as `vblank_start` -> no commit this frame; commit on the following frame's `vblank_start`.
- Wrap: 256 consecutive commits -> `frame_count` returns to 0; a `req0_valid` held during HELD/COMMIT sees `req0_ready`=0 until IDLE.
